sq_image_burst_fetcher: RTL



---
 rtl/pkg_SQImageCache.sv | 18 +
 rtl/sq_fetch_fifo.sv | 53 +++++
 rtl/sq_image_burst_fetcher.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pkg_SQImageCache.sv
// Shared constants and types for the SQ image cache fetch path.
package pkg_SQImageCache;

  localparam int unsigned WORD_SIZE         = 32;
  localparam int unsigned ROW_WIDTH         = 3;
  localparam int unsigned COL_WIDTH         = 3;
  localparam int unsigned TOTAL_WORDS       = 2 ** (ROW_WIDTH + COL_WIDTH);
  localparam int unsigned DEFAULT_BURST_LEN = 8;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StReq,
    StDrain,
    StDone
  } fetch_state_e;

endpackage

// File: rtl/sq_fetch_fifo.sv
// Show-ahead FIFO: rdata presents the head word whenever the FIFO is not empty.
module sq_fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign count   = count_q;
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/sq_image_burst_fetcher.sv
// Avalon-MM burst reader that streams one square image to the SQ cache loader.
// Define SQ_FETCH_STATS_EN to add the stall_cycles / overflow_err statistics ports.
module sq_image_burst_fetcher #(
  parameter int unsigned AVM_ADDR_WIDTH = 32,
  parameter int unsigned WORD_SIZE      = pkg_SQImageCache::WORD_SIZE,
  parameter int unsigned ROW_WIDTH      = pkg_SQImageCache::ROW_WIDTH,
  parameter int unsigned COL_WIDTH      = pkg_SQImageCache::COL_WIDTH,
  parameter int unsigned BURST_LEN      = pkg_SQImageCache::DEFAULT_BURST_LEN,
  parameter int unsigned FIFO_DEPTH     = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [AVM_ADDR_WIDTH-1:0]     base_addr,
  output logic                          busy,
  output logic                          done,
  output logic [AVM_ADDR_WIDTH-1:0]     avm_address,
  output logic                          avm_read,
  output logic [$clog2(BURST_LEN):0]    avm_burstcount,
  input  logic                          avm_waitrequest,
  input  logic [WORD_SIZE-1:0]          avm_readdata,
  input  logic                          avm_readdatavalid,
  output logic [WORD_SIZE-1:0]          data,
  output logic                          data_ready,
  input  logic                          data_wanted
`ifdef SQ_FETCH_STATS_EN
  ,
  output logic [31:0]                   stall_cycles,
  output logic [0:0]                    overflow_err
`endif
);

  import pkg_SQImageCache::*;

  localparam int unsigned ImgW       = ROW_WIDTH + COL_WIDTH;
  localparam int unsigned WordsW     = ImgW + 1;
  localparam int unsigned TotalWords = 2 ** ImgW;
  localparam int unsigned NumBursts  = TotalWords / BURST_LEN;
  localparam int unsigned BurstW     = $clog2(NumBursts) + 1;
  localparam int unsigned CntW       = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BcW        = $clog2(BURST_LEN) + 1;
  localparam int unsigned BurstBytes = BURST_LEN * (WORD_SIZE / 8);

  fetch_state_e              state_q, state_d;
  logic [AVM_ADDR_WIDTH-1:0] base_q, base_d;
  logic [BurstW-1:0]         bursts_q, bursts_d;
  logic [WordsW-1:0]         words_q, words_d;
  logic [CntW-1:0]           outstanding_q, outstanding_d;

  logic                      fifo_full, fifo_empty, fifo_push, push_drop;
  logic [CntW-1:0]           fifo_count;
  logic                      handoff, rdv_accept, read_accept, credit_ok;
  logic [AVM_ADDR_WIDTH-1:0] burst_off;

  assign avm_burstcount = BcW'(BURST_LEN);
  assign data_ready     = !fifo_empty;
  assign handoff        = data_ready && data_wanted;
  // Beats with nothing outstanding belong to a burst aborted by reset.
  assign rdv_accept     = avm_readdatavalid && (outstanding_q != '0);
  assign push_drop      = rdv_accept && fifo_full && !handoff;
  assign fifo_push      = rdv_accept && !push_drop;
  assign read_accept    = (state_q == StReq) && !avm_waitrequest;
  assign credit_ok      = ({1'b0, fifo_count} + {1'b0, outstanding_q} + (CntW + 1)'(BURST_LEN))
                          <= (CntW + 1)'(FIFO_DEPTH);
  assign burst_off      = AVM_ADDR_WIDTH'(bursts_q) * AVM_ADDR_WIDTH'(BurstBytes);

  sq_fetch_fifo #(
    .WIDTH (WORD_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (handoff),
    .wdata (avm_readdata),
    .rdata (data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    outstanding_d = outstanding_q;
    if (read_accept) outstanding_d = outstanding_d + CntW'(BURST_LEN);
    if (rdv_accept)  outstanding_d = outstanding_d - 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    bursts_d    = bursts_q;
    words_d     = words_q;
    busy        = 1'b0;
    done        = 1'b0;
    avm_read    = 1'b0;
    avm_address = '0;
    if (handoff) words_d = words_q + 1'b1;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_d   = base_addr;
          bursts_d = '0;
          words_d  = '0;
          state_d  = StCheck;
        end
      end
      StCheck: begin
        busy = 1'b1;
        if (bursts_q == BurstW'(NumBursts)) begin
          state_d = StDrain;
        end else if (credit_ok) begin
          state_d = StReq;
        end
      end
      StReq: begin
        busy        = 1'b1;
        avm_read    = 1'b1;
        avm_address = base_q + burst_off;
        if (!avm_waitrequest) begin
          bursts_d = bursts_q + 1'b1;
          state_d  = StCheck;
        end
      end
      StDrain: begin
        busy = 1'b1;
        if (words_q == WordsW'(TotalWords)) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      base_q        <= '0;
      bursts_q      <= '0;
      words_q       <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      bursts_q      <= bursts_d;
      words_q       <= words_d;
      outstanding_q <= outstanding_d;
    end
  end

`ifdef SQ_FETCH_STATS_EN
  logic [31:0] stall_q;
  logic        overflow_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if ((state_q == StIdle) && start) begin
        stall_q <= '0;
      end else if (busy && data_ready && !data_wanted && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
      if (push_drop) overflow_q <= 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign overflow_err = overflow_q;
`endif

endmodule
